reorder_buffer: RTL and testbench
=================================

# reorder_buffer

Circular reorder buffer between the decoder/dispatch stage and the architectural register file. It allocates a ROB tag per issued instruction and captures results from the common data bus (CDB). It answers operand-forwarding queries from the decoder and retires results in program order, one per cycle, onto the register file's ROB-write port. On a committed branch mispredict it drives the machine-wide rollback.

## Interface
Parameters:
- `ROB_DEPTH`, 15: usable entries. Tags are 1..ROB_DEPTH; tag 0 (`ZERO_ROB`) means "no tag". ROB_DEPTH+1 must equal 2^`ROB_WIDTH`.

Ports:
- `clk`  in  1  clock.
- `rst`  in  1  reset, synchronous, active-low: `rst`==0 at a rising edge resets.
- `ena`  in  1  global enable; 0 freezes allocation and commit (CDB capture continues).
- `in_issue_ena`  in  1  decoder requests an allocation this cycle.
- `in_issue_rd`  in  `REG_WIDTH`  destination register; 0 = no register write.
- `in_issue_is_branch`  in  1  instruction is a branch/jump.
- `out_issue_tag`  out  `ROB_WIDTH`  tag that the next allocation receives (combinational).
- `out_full`  out  1  no free entry; allocation is refused.
- `in_cdb_valid`  in  1  result broadcast valid.
- `in_cdb_tag`  in  `ROB_WIDTH`  producing entry.
- `in_cdb_value`  in  `DATA_WIDTH`  result value.
- `in_cdb_mispredict`  in  1  branch resolved against its prediction.
- `in_cdb_target`  in  `DATA_WIDTH`  correct next PC for a mispredicted branch.
- `in_query_tag1`, `in_query_tag2`  in  `ROB_WIDTH`  operand tags read from the register file.
- `out_query_ready1`, `out_query_ready2`  out  1  result available (combinational).
- `out_query_value1`, `out_query_value2`  out  `DATA_WIDTH`  forwarded value.
- `out_commit_reg`  out  `REG_WIDTH`  register-file write index; 0 = no write this cycle.
- `out_commit_tag`  out  `ROB_WIDTH`  tag of the committing entry.
- `out_commit_value`  out  `DATA_WIDTH`  committed value.
- `out_rollback`  out  1  flush pulse to all stages.
- `out_rollback_pc`  out  `DATA_WIDTH`  redirect PC, valid while `out_rollback`=1.

## Operation
- Per-entry state: valid, ready, rd, is_branch, mispredict, value, target. Pointers `head`/`tail` range 1..ROB_DEPTH and wrap ROB_DEPTH→1. `count` runs 0..ROB_DEPTH.
- `out_full` = (`count`==ROB_DEPTH). `out_issue_tag` = `tail`.
- Allocate when `ena` & `in_issue_ena` & !`out_full` & state RUN. The entry is written valid, not ready. `tail` advances.
- CDB capture: if `in_cdb_valid` and the entry is valid, set ready, value, mispredict and target. A capture to an invalid entry is ignored.
- Query: ready = entry valid & (ready | (`in_cdb_valid` & `in_cdb_tag`==tag)). The CDB value bypasses the stored value. Tag 0 returns ready=0, value 0.
- Commit when `ena`, RUN, `count`>0, and the head entry is ready. The registered outputs carry rd, the head tag and the value. The entry is invalidated and `head` advances.
- FSM, two states:
  - RUN: commits a mispredicted branch normally (including its rd write), latches its target, then goes to FLUSH.
  - FLUSH: asserts `out_rollback`=1 and `out_rollback_pc`=target for exactly one cycle. It clears all valid bits and sets `head`=`tail`=1, `count`=0, then returns to RUN. No allocation and no commit happen in FLUSH.
- Simultaneous allocate and commit: `count` is unchanged. `out_full` is evaluated on the pre-edge count, so a full ROB refuses allocation even when it commits in the same cycle.

## Timing
- Reset values: `head`=`tail`=1, `count`=0, all valid=0, state RUN.
- Reset values of outputs: `out_commit_reg`=0, `out_commit_tag`=0, `out_commit_value`=0, `out_rollback`=0, `out_rollback_pc`=0, `out_full`=0, `out_issue_tag`=1.
- Reset has priority over FLUSH and over all traffic. Reset asserted mid-flush leaves no rollback pulse.
- Commit outputs are registered and hold for one cycle, then return to reg 0 / tag 0. The register file consumes them on the following edge.
- Latency:
  - CDB result at edge N makes the entry ready after N. The earliest commit output is registered at edge N+1.
  - Rollback is registered one edge after the branch's commit output, so the rd write is never lost to rollback priority.
- A result can be forwarded via query in the same cycle it appears on the CDB.

## Structure
- `constant.v` holds `REG_WIDTH`, `ROB_WIDTH`, `DATA_WIDTH`, `ZERO_ROB`, `ZERO_DATA` and `TRUE`/`FALSE`. Add `ROB_SIZE` there, plus the FSM encodings `ROB_RUN` and `ROB_FLUSH`.
- Single flat module; entry fields are per-field arrays. No sub-module is warranted.

## Test plan
- Reset, then allocate rd=5 and CDB tag 1 value 0x1234 → one cycle later `out_commit_reg`=5, `out_commit_tag`=1, `out_commit_value`=0x1234.
- Allocate 15 entries → `out_full`=1. A 16th request is refused and `tail` stays at 1 (wrapped). After one commit, the next allocation gets tag 1.
- Results for tags 3, 2, 1 arrive in that order → commits appear in order 1, 2, 3 on consecutive cycles.
- Query tag 4 while the CDB broadcasts tag 4 value 0xBEEF → ready=1, value=0xBEEF in the same cycle.
- Branch at tag 2 with rd=1, mispredict, target 0x400, with tag 3 still pending:
  - commit cycle: reg 1 is written.
  - next cycle: `out_rollback`=1 with PC 0x400.
  - after that: `count`=0 and the next allocation gets tag 1.
- Drive `rst`=0 during the FLUSH cycle → no rollback pulse, and all outputs take their reset values.

Source files
------------

// File: rtl/reorder_buffer_pkg.sv
// Shared widths, tag constants and FSM encoding for the reorder buffer.
// Tag 0 is reserved as "no tag", so a 4-bit tag addresses 15 usable entries.
package reorder_buffer_pkg;

    localparam int unsigned REG_WIDTH  = 5;
    localparam int unsigned ROB_WIDTH  = 4;
    localparam int unsigned DATA_WIDTH = 32;
    localparam int unsigned ROB_SIZE   = 15;

    localparam logic [ROB_WIDTH-1:0]  ZERO_ROB  = '0;
    localparam logic [ROB_WIDTH-1:0]  FIRST_ROB = ROB_WIDTH'(1);
    localparam logic [DATA_WIDTH-1:0] ZERO_DATA = '0;
    localparam logic                  TRUE      = 1'b1;
    localparam logic                  FALSE     = 1'b0;

    typedef enum logic {
        ROB_RUN   = 1'b0,
        ROB_FLUSH = 1'b1
    } rob_state_e;

    // Pointers live in 1..depth and wrap from depth back to 1.
    function automatic logic [ROB_WIDTH-1:0] rob_next_ptr(input logic [ROB_WIDTH-1:0] ptr,
                                                          input int unsigned depth);
        if (32'(ptr) >= depth) begin
            return FIRST_ROB;
        end
        return ptr + ROB_WIDTH'(1);
    endfunction

endpackage

// File: rtl/reorder_buffer.sv
// Circular reorder buffer: allocates tags, captures CDB results, forwards operands,
// retires in program order and drives the rollback after a mispredicted branch commits.
module reorder_buffer
    import reorder_buffer_pkg::*;
#(
    parameter int unsigned ROB_DEPTH = ROB_SIZE
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  ena,
    input  logic                  in_issue_ena,
    input  logic [REG_WIDTH-1:0]  in_issue_rd,
    input  logic                  in_issue_is_branch,
    output logic [ROB_WIDTH-1:0]  out_issue_tag,
    output logic                  out_full,
    input  logic                  in_cdb_valid,
    input  logic [ROB_WIDTH-1:0]  in_cdb_tag,
    input  logic [DATA_WIDTH-1:0] in_cdb_value,
    input  logic                  in_cdb_mispredict,
    input  logic [DATA_WIDTH-1:0] in_cdb_target,
    input  logic [ROB_WIDTH-1:0]  in_query_tag1,
    input  logic [ROB_WIDTH-1:0]  in_query_tag2,
    output logic                  out_query_ready1,
    output logic                  out_query_ready2,
    output logic [DATA_WIDTH-1:0] out_query_value1,
    output logic [DATA_WIDTH-1:0] out_query_value2,
    output logic [REG_WIDTH-1:0]  out_commit_reg,
    output logic [ROB_WIDTH-1:0]  out_commit_tag,
    output logic [DATA_WIDTH-1:0] out_commit_value,
    output logic                  out_rollback,
    output logic [DATA_WIDTH-1:0] out_rollback_pc
);

    // Index 0 is never allocated, so valid_q[0] stays 0 and tag 0 never hits.
    logic                  valid_q  [ROB_DEPTH+1];
    logic                  valid_d  [ROB_DEPTH+1];
    logic                  ready_q  [ROB_DEPTH+1];
    logic                  ready_d  [ROB_DEPTH+1];
    logic                  branch_q [ROB_DEPTH+1];
    logic                  branch_d [ROB_DEPTH+1];
    logic                  misp_q   [ROB_DEPTH+1];
    logic                  misp_d   [ROB_DEPTH+1];
    logic [REG_WIDTH-1:0]  rd_q     [ROB_DEPTH+1];
    logic [REG_WIDTH-1:0]  rd_d     [ROB_DEPTH+1];
    logic [DATA_WIDTH-1:0] value_q  [ROB_DEPTH+1];
    logic [DATA_WIDTH-1:0] value_d  [ROB_DEPTH+1];
    logic [DATA_WIDTH-1:0] target_q [ROB_DEPTH+1];
    logic [DATA_WIDTH-1:0] target_d [ROB_DEPTH+1];

    logic [ROB_WIDTH-1:0]  head_q, head_d, tail_q, tail_d, count_q, count_d;
    rob_state_e            state_q, state_d;
    logic [DATA_WIDTH-1:0] flush_pc_q, flush_pc_d;
    logic [REG_WIDTH-1:0]  commit_reg_q, commit_reg_d;
    logic [ROB_WIDTH-1:0]  commit_tag_q, commit_tag_d;
    logic [DATA_WIDTH-1:0] commit_value_q, commit_value_d;
    logic                  rollback_q, rollback_d;
    logic [DATA_WIDTH-1:0] rollback_pc_q, rollback_pc_d;

    logic do_alloc, do_commit, q1_bypass, q2_bypass;

    assign out_full      = (count_q == ROB_WIDTH'(ROB_DEPTH));
    assign out_issue_tag = tail_q;
    assign do_alloc      = ena && in_issue_ena && !out_full && (state_q == ROB_RUN);
    assign do_commit     = ena && (state_q == ROB_RUN) && (count_q != '0) && ready_q[head_q];

    assign q1_bypass        = in_cdb_valid && (in_cdb_tag == in_query_tag1);
    assign q2_bypass        = in_cdb_valid && (in_cdb_tag == in_query_tag2);
    assign out_query_ready1 = (in_query_tag1 != ZERO_ROB) && valid_q[in_query_tag1] &&
                              (ready_q[in_query_tag1] || q1_bypass);
    assign out_query_ready2 = (in_query_tag2 != ZERO_ROB) && valid_q[in_query_tag2] &&
                              (ready_q[in_query_tag2] || q2_bypass);
    assign out_query_value1 = !out_query_ready1 ? ZERO_DATA :
                              q1_bypass ? in_cdb_value : value_q[in_query_tag1];
    assign out_query_value2 = !out_query_ready2 ? ZERO_DATA :
                              q2_bypass ? in_cdb_value : value_q[in_query_tag2];

    always_comb begin
        valid_d        = valid_q;
        ready_d        = ready_q;
        branch_d       = branch_q;
        misp_d         = misp_q;
        rd_d           = rd_q;
        value_d        = value_q;
        target_d       = target_q;
        head_d         = head_q;
        tail_d         = tail_q;
        count_d        = count_q;
        state_d        = state_q;
        flush_pc_d     = flush_pc_q;
        commit_reg_d   = '0;
        commit_tag_d   = ZERO_ROB;
        commit_value_d = ZERO_DATA;
        rollback_d     = FALSE;
        rollback_pc_d  = ZERO_DATA;

        if (in_cdb_valid && valid_q[in_cdb_tag]) begin
            ready_d[in_cdb_tag]  = TRUE;
            value_d[in_cdb_tag]  = in_cdb_value;
            misp_d[in_cdb_tag]   = in_cdb_mispredict;
            target_d[in_cdb_tag] = in_cdb_target;
        end

        if (do_commit) begin
            commit_reg_d    = rd_q[head_q];
            commit_tag_d    = head_q;
            commit_value_d  = value_q[head_q];
            valid_d[head_q] = FALSE;
            head_d          = rob_next_ptr(head_q, ROB_DEPTH);
            if (branch_q[head_q] && misp_q[head_q]) begin
                flush_pc_d = target_q[head_q];
                state_d    = ROB_FLUSH;
            end
        end

        if (do_alloc) begin
            valid_d[tail_q]  = TRUE;
            ready_d[tail_q]  = FALSE;
            misp_d[tail_q]   = FALSE;
            rd_d[tail_q]     = in_issue_rd;
            branch_d[tail_q] = in_issue_is_branch;
            tail_d           = rob_next_ptr(tail_q, ROB_DEPTH);
        end

        if (do_alloc && !do_commit) begin
            count_d = count_q + ROB_WIDTH'(1);
        end else if (!do_alloc && do_commit) begin
            count_d = count_q - ROB_WIDTH'(1);
        end

        // Flush overrides any CDB capture landing in the same cycle.
        if (state_q == ROB_FLUSH) begin
            for (int i = 0; i <= int'(ROB_DEPTH); i++) begin
                valid_d[i] = FALSE;
            end
            head_d        = FIRST_ROB;
            tail_d        = FIRST_ROB;
            count_d       = '0;
            state_d       = ROB_RUN;
            rollback_d    = TRUE;
            rollback_pc_d = flush_pc_q;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            for (int i = 0; i <= int'(ROB_DEPTH); i++) begin
                valid_q[i] <= FALSE;
            end
            head_q         <= FIRST_ROB;
            tail_q         <= FIRST_ROB;
            count_q        <= '0;
            state_q        <= ROB_RUN;
            flush_pc_q     <= ZERO_DATA;
            commit_reg_q   <= '0;
            commit_tag_q   <= ZERO_ROB;
            commit_value_q <= ZERO_DATA;
            rollback_q     <= FALSE;
            rollback_pc_q  <= ZERO_DATA;
        end else begin
            valid_q        <= valid_d;
            head_q         <= head_d;
            tail_q         <= tail_d;
            count_q        <= count_d;
            state_q        <= state_d;
            flush_pc_q     <= flush_pc_d;
            commit_reg_q   <= commit_reg_d;
            commit_tag_q   <= commit_tag_d;
            commit_value_q <= commit_value_d;
            rollback_q     <= rollback_d;
            rollback_pc_q  <= rollback_pc_d;
        end
    end

    // Payload fields are only meaningful while valid, so they carry no reset.
    always_ff @(posedge clk) begin
        ready_q  <= ready_d;
        branch_q <= branch_d;
        misp_q   <= misp_d;
        rd_q     <= rd_d;
        value_q  <= value_d;
        target_q <= target_d;
    end

    assign out_commit_reg   = commit_reg_q;
    assign out_commit_tag   = commit_tag_q;
    assign out_commit_value = commit_value_q;
    assign out_rollback     = rollback_q;
    assign out_rollback_pc  = rollback_pc_q;

endmodule

// File: tb/tb_reorder_buffer.sv
// Scenario bench for reorder_buffer: expected commits are queued at allocation
// and checked in program order as the commit port produces them.
module tb_reorder_buffer;

    logic        clk = 1'b0;
    logic        rst, ena, in_issue_ena, in_issue_is_branch;
    logic [4:0]  in_issue_rd;
    logic [3:0]  out_issue_tag;
    logic        out_full;
    logic        in_cdb_valid, in_cdb_mispredict;
    logic [3:0]  in_cdb_tag, in_query_tag1, in_query_tag2;
    logic [31:0] in_cdb_value, in_cdb_target;
    logic        out_query_ready1, out_query_ready2;
    logic [31:0] out_query_value1, out_query_value2;
    logic [4:0]  out_commit_reg;
    logic [3:0]  out_commit_tag;
    logic [31:0] out_commit_value;
    logic        out_rollback;
    logic [31:0] out_rollback_pc;

    typedef struct packed {
        logic [4:0]  rd;
        logic [3:0]  tag;
        logic [31:0] val;
    } exp_t;

    exp_t sb[$];
    exp_t mon_exp;
    int   checks = 0;
    int   errors = 0;
    logic mon_en = 1'b0;

    reorder_buffer dut (
        .clk                (clk),
        .rst                (rst),
        .ena                (ena),
        .in_issue_ena       (in_issue_ena),
        .in_issue_rd        (in_issue_rd),
        .in_issue_is_branch (in_issue_is_branch),
        .out_issue_tag      (out_issue_tag),
        .out_full           (out_full),
        .in_cdb_valid       (in_cdb_valid),
        .in_cdb_tag         (in_cdb_tag),
        .in_cdb_value       (in_cdb_value),
        .in_cdb_mispredict  (in_cdb_mispredict),
        .in_cdb_target      (in_cdb_target),
        .in_query_tag1      (in_query_tag1),
        .in_query_tag2      (in_query_tag2),
        .out_query_ready1   (out_query_ready1),
        .out_query_ready2   (out_query_ready2),
        .out_query_value1   (out_query_value1),
        .out_query_value2   (out_query_value2),
        .out_commit_reg     (out_commit_reg),
        .out_commit_tag     (out_commit_tag),
        .out_commit_value   (out_commit_value),
        .out_rollback       (out_rollback),
        .out_rollback_pc    (out_rollback_pc)
    );

    always #5 clk = ~clk;

    // Every nonzero commit tag must match the oldest outstanding expectation.
    always @(negedge clk) begin
        if (mon_en && (out_commit_tag !== 4'd0)) begin
            checks++;
            if (sb.size() == 0) begin
                errors++;
                $display("FAIL commit_unexpected got reg=%0d tag=%0d val=%h expected none",
                         out_commit_reg, out_commit_tag, out_commit_value);
            end else begin
                mon_exp = sb.pop_front();
                if ({out_commit_reg, out_commit_tag, out_commit_value} !==
                    {mon_exp.rd, mon_exp.tag, mon_exp.val}) begin
                    errors++;
                    $display("FAIL commit_order got reg=%0d tag=%0d val=%h expected reg=%0d tag=%0d val=%h",
                             out_commit_reg, out_commit_tag, out_commit_value,
                             mon_exp.rd, mon_exp.tag, mon_exp.val);
                end
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic apply_reset();
        rst = 1'b0;
        tick();
        tick();
        rst = 1'b1;
    endtask

    task automatic alloc(input logic [4:0] rd, input logic br);
        in_issue_ena       = 1'b1;
        in_issue_rd        = rd;
        in_issue_is_branch = br;
        tick();
        in_issue_ena       = 1'b0;
        in_issue_is_branch = 1'b0;
    endtask

    task automatic cdb(input logic [3:0] tag, input logic [31:0] val,
                       input logic misp, input logic [31:0] tgt);
        in_cdb_valid      = 1'b1;
        in_cdb_tag        = tag;
        in_cdb_value      = val;
        in_cdb_mispredict = misp;
        in_cdb_target     = tgt;
        tick();
        in_cdb_valid      = 1'b0;
        in_cdb_mispredict = 1'b0;
    endtask

    task automatic wait_drain(input string name);
        int n = 0;
        while (sb.size() != 0 && n < 100) begin
            tick();
            n++;
        end
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL %s_drain got %0d outstanding commits expected 0", name, sb.size());
            sb.delete();
        end
    endtask

    task automatic test_reset();
        ena = 1'b1; in_issue_ena = 1'b0; in_issue_rd = '0; in_issue_is_branch = 1'b0;
        in_cdb_valid = 1'b0; in_cdb_tag = '0; in_cdb_value = '0; in_cdb_mispredict = 1'b0;
        in_cdb_target = '0; in_query_tag1 = '0; in_query_tag2 = '0;
        apply_reset();
        mon_en = 1'b1;
        checks++;
        if ({out_commit_reg, out_commit_tag, out_commit_value} !== 41'd0) begin
            errors++;
            $display("FAIL reset_commit got reg=%0d tag=%0d val=%h expected 0",
                     out_commit_reg, out_commit_tag, out_commit_value);
        end
        checks++;
        if ({out_rollback, out_rollback_pc, out_full} !== 34'd0) begin
            errors++;
            $display("FAIL reset_rollback_full got rb=%b pc=%h full=%b expected 0",
                     out_rollback, out_rollback_pc, out_full);
        end
        checks++;
        if (out_issue_tag !== 4'd1) begin
            errors++;
            $display("FAIL reset_issue_tag got %0d expected 1", out_issue_tag);
        end
    endtask

    task automatic test_basic();
        apply_reset();
        alloc(5'd5, 1'b0);
        sb.push_back('{rd: 5'd5, tag: 4'd1, val: 32'h1234});
        cdb(4'd1, 32'h1234, 1'b0, 32'h0);
        tick();
        checks++;
        if ({out_commit_reg, out_commit_tag, out_commit_value} !== {5'd5, 4'd1, 32'h1234}) begin
            errors++;
            $display("FAIL basic_commit got reg=%0d tag=%0d val=%h expected reg=5 tag=1 val=1234",
                     out_commit_reg, out_commit_tag, out_commit_value);
        end
        tick();
        checks++;
        if ({out_commit_reg, out_commit_tag} !== 9'd0) begin
            errors++;
            $display("FAIL basic_commit_clear got reg=%0d tag=%0d expected 0",
                     out_commit_reg, out_commit_tag);
        end
        wait_drain("basic");
    endtask

    task automatic test_in_order();
        apply_reset();
        for (int i = 1; i <= 3; i++) begin
            alloc(5'(9 + i), 1'b0);
            sb.push_back('{rd: 5'(9 + i), tag: 4'(i), val: 32'hC00 + 32'(i)});
        end
        for (int i = 3; i >= 1; i--) begin
            cdb(4'(i), 32'hC00 + 32'(i), 1'b0, 32'h0);
        end
        for (int i = 1; i <= 3; i++) begin
            tick();
            checks++;
            if (out_commit_tag !== 4'(i)) begin
                errors++;
                $display("FAIL order_commit_tag got %0d expected %0d", out_commit_tag, i);
            end
        end
        wait_drain("order");
    endtask

    task automatic test_full();
        apply_reset();
        for (int i = 1; i <= 15; i++) begin
            checks++;
            if (out_issue_tag !== 4'(i)) begin
                errors++;
                $display("FAIL full_issue_tag got %0d expected %0d", out_issue_tag, i);
            end
            alloc(5'(i), 1'b0);
            sb.push_back('{rd: 5'(i), tag: 4'(i), val: 32'h1000 + 32'(i)});
        end
        alloc(5'd9, 1'b0);
        checks++;
        if ({out_full, out_issue_tag} !== {1'b1, 4'd1}) begin
            errors++;
            $display("FAIL full_refuse got full=%b tag=%0d expected full=1 tag=1",
                     out_full, out_issue_tag);
        end
        cdb(4'd1, 32'h1001, 1'b0, 32'h0);
        tick();
        checks++;
        if ({out_full, out_issue_tag} !== {1'b0, 4'd1}) begin
            errors++;
            $display("FAIL full_after_commit got full=%b tag=%0d expected full=0 tag=1",
                     out_full, out_issue_tag);
        end
        alloc(5'd7, 1'b0);
        sb.push_back('{rd: 5'd7, tag: 4'd1, val: 32'hAAAA});
        checks++;
        if ({out_full, out_issue_tag} !== {1'b1, 4'd2}) begin
            errors++;
            $display("FAIL full_realloc got full=%b tag=%0d expected full=1 tag=2",
                     out_full, out_issue_tag);
        end
        for (int i = 2; i <= 15; i++) begin
            cdb(4'(i), 32'h1000 + 32'(i), 1'b0, 32'h0);
        end
        cdb(4'd1, 32'hAAAA, 1'b0, 32'h0);
        wait_drain("full");
    endtask

    task automatic test_query();
        apply_reset();
        for (int i = 1; i <= 4; i++) begin
            alloc(5'(i), 1'b0);
            sb.push_back('{rd: 5'(i), tag: 4'(i), val: (i == 4) ? 32'hBEEF : 32'(i * 17)});
        end
        in_query_tag1 = 4'd4;
        in_query_tag2 = 4'd3;
        in_cdb_valid  = 1'b1;
        in_cdb_tag    = 4'd4;
        in_cdb_value  = 32'hBEEF;
        #1;
        checks++;
        if ({out_query_ready1, out_query_value1} !== {1'b1, 32'hBEEF}) begin
            errors++;
            $display("FAIL query_bypass got rdy=%b val=%h expected rdy=1 val=beef",
                     out_query_ready1, out_query_value1);
        end
        checks++;
        if ({out_query_ready2, out_query_value2} !== 33'd0) begin
            errors++;
            $display("FAIL query_pending got rdy=%b val=%h expected rdy=0 val=0",
                     out_query_ready2, out_query_value2);
        end
        tick();
        in_cdb_valid = 1'b0;
        #1;
        checks++;
        if ({out_query_ready1, out_query_value1} !== {1'b1, 32'hBEEF}) begin
            errors++;
            $display("FAIL query_stored got rdy=%b val=%h expected rdy=1 val=beef",
                     out_query_ready1, out_query_value1);
        end
        in_query_tag1 = 4'd0;
        #1;
        checks++;
        if ({out_query_ready1, out_query_value1} !== 33'd0) begin
            errors++;
            $display("FAIL query_tag0 got rdy=%b val=%h expected rdy=0 val=0",
                     out_query_ready1, out_query_value1);
        end
        in_query_tag2 = 4'd0;
        for (int i = 1; i <= 3; i++) begin
            cdb(4'(i), 32'(i * 17), 1'b0, 32'h0);
        end
        wait_drain("query");
    endtask

    task automatic test_mispredict();
        apply_reset();
        alloc(5'd3, 1'b0);
        sb.push_back('{rd: 5'd3, tag: 4'd1, val: 32'h31});
        alloc(5'd1, 1'b1);
        sb.push_back('{rd: 5'd1, tag: 4'd2, val: 32'h44});
        alloc(5'd4, 1'b0);
        cdb(4'd1, 32'h31, 1'b0, 32'h0);
        cdb(4'd2, 32'h44, 1'b1, 32'h400);
        tick();
        checks++;
        if ({out_commit_reg, out_commit_tag, out_rollback} !== {5'd1, 4'd2, 1'b0}) begin
            errors++;
            $display("FAIL misp_commit got reg=%0d tag=%0d rb=%b expected reg=1 tag=2 rb=0",
                     out_commit_reg, out_commit_tag, out_rollback);
        end
        // Tag 3 resolves during the flush cycle; it must neither commit nor survive.
        cdb(4'd3, 32'h55, 1'b0, 32'h0);
        checks++;
        if ({out_rollback, out_rollback_pc} !== {1'b1, 32'h400}) begin
            errors++;
            $display("FAIL misp_rollback got rb=%b pc=%h expected rb=1 pc=400",
                     out_rollback, out_rollback_pc);
        end
        in_query_tag1 = 4'd3;
        #1;
        checks++;
        if ({out_issue_tag, out_full, out_query_ready1} !== {4'd1, 1'b0, 1'b0}) begin
            errors++;
            $display("FAIL misp_flushed got tag=%0d full=%b qrdy=%b expected tag=1 full=0 qrdy=0",
                     out_issue_tag, out_full, out_query_ready1);
        end
        in_query_tag1 = 4'd0;
        tick();
        checks++;
        if (out_rollback !== 1'b0) begin
            errors++;
            $display("FAIL misp_rollback_pulse got rb=%b expected 0", out_rollback);
        end
        alloc(5'd6, 1'b0);
        sb.push_back('{rd: 5'd6, tag: 4'd1, val: 32'h66});
        checks++;
        if (out_issue_tag !== 4'd2) begin
            errors++;
            $display("FAIL misp_realloc got tag=%0d expected 2", out_issue_tag);
        end
        cdb(4'd1, 32'h66, 1'b0, 32'h0);
        wait_drain("misp");
    endtask

    task automatic test_reset_in_flush();
        apply_reset();
        alloc(5'd2, 1'b1);
        sb.push_back('{rd: 5'd2, tag: 4'd1, val: 32'h77});
        cdb(4'd1, 32'h77, 1'b1, 32'h800);
        tick();
        checks++;
        if (out_commit_tag !== 4'd1) begin
            errors++;
            $display("FAIL rstflush_commit got tag=%0d expected 1", out_commit_tag);
        end
        rst = 1'b0;
        tick();
        checks++;
        if ({out_rollback, out_rollback_pc, out_commit_reg, out_commit_tag, out_commit_value,
             out_full, out_issue_tag} !== {1'b1 ^ 1'b1, 32'd0, 5'd0, 4'd0, 32'd0, 1'b0, 4'd1}) begin
            errors++;
            $display("FAIL rstflush_outputs got rb=%b pc=%h reg=%0d tag=%0d val=%h full=%b itag=%0d expected reset values",
                     out_rollback, out_rollback_pc, out_commit_reg, out_commit_tag,
                     out_commit_value, out_full, out_issue_tag);
        end
        rst = 1'b1;
        tick();
        checks++;
        if (out_rollback !== 1'b0) begin
            errors++;
            $display("FAIL rstflush_late_pulse got rb=%b expected 0", out_rollback);
        end
        wait_drain("rstflush");
    endtask

    initial begin
        test_reset();
        test_basic();
        test_in_order();
        test_full();
        test_query();
        test_mispredict();
        test_reset_in_flush();
        tick();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
